// File: rtl/datapath_mc_pkg.sv
// -----------------------------------------------------------------------------
// datapath_mc_pkg
// Shared definitions for the multi-cycle single-bus datapath:
//   - OPW and the ALU opcode values driven by the control unit
//   - sequencer state type for the MUL/DIV engine
//   - helpers for the iteration-counter width and multi-cycle opcode decode
// -----------------------------------------------------------------------------
package datapath_mc_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_SUB  = 4'd1;
    localparam logic [OPW-1:0] OP_AND  = 4'd2;
    localparam logic [OPW-1:0] OP_OR   = 4'd3;
    localparam logic [OPW-1:0] OP_SHR  = 4'd4;
    localparam logic [OPW-1:0] OP_SHRA = 4'd5;
    localparam logic [OPW-1:0] OP_SHL  = 4'd6;
    localparam logic [OPW-1:0] OP_ROR  = 4'd7;
    localparam logic [OPW-1:0] OP_ROL  = 4'd8;
    localparam logic [OPW-1:0] OP_NEG  = 4'd9;
    localparam logic [OPW-1:0] OP_NOT  = 4'd10;
    localparam logic [OPW-1:0] OP_MUL  = 4'd11;
    localparam logic [OPW-1:0] OP_DIV  = 4'd12;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    // Width of a counter able to hold 0..width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic is_multicycle(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/datapath_mc_muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential signed multiplier (shift-add) / divider (restoring), one
// iteration per clock, WIDTH iterations per operation. Both work on operand
// magnitudes; signs are applied when the final iteration completes.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset (aborts a run)
//   i_start           begin an operation (ignored while busy)
//   i_a, i_b          operands (a*b or a/b), two's complement
//   i_op              OP_MUL or OP_DIV
//   o_busy            operation in progress
//   o_last            final iteration happens at the coming edge; o_hi/o_lo
//                     are valid in this cycle
//   o_done            one-cycle pulse after the result edge
//   o_hi, o_lo        result (product high/low, or remainder/quotient)
// -----------------------------------------------------------------------------
module muldiv_seq
    import datapath_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OPW-1:0]   i_op,
    output logic             o_busy,
    output logic             o_last,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNTW = cnt_width(WIDTH);

    md_state_t r_state, w_state_next;

    logic [CNTW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_q;      // product / quotient negative
    logic               r_neg_r;      // remainder negative (follows dividend)
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_dividend;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next, w_prod;
    logic [WIDTH:0]     w_shift, w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next, w_quo_next;
    logic               w_last;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1), still exact unsigned
    assign w_mag_a = i_a[WIDTH-1] ? (-i_a) : i_a;
    assign w_mag_b = i_b[WIDTH-1] ? (-i_b) : i_b;

    // One multiplier step: add the shifted multiplicand if the current bit is set
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg_q ? (-w_acc_next) : w_acc_next;

    // One restoring-division step: bit WIDTH of the difference is the borrow
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_next = MD_RUN;
            MD_RUN:  if (r_cnt == CNTW'(WIDTH - 1)) w_state_next = MD_IDLE;
            default: w_state_next = MD_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy = 1'b0;
        w_last = 1'b0;
        case (r_state)
            MD_RUN: begin
                o_busy = 1'b1;
                w_last = (r_cnt == CNTW'(WIDTH - 1));
            end
            default: begin
                o_busy = 1'b0;
                w_last = 1'b0;
            end
        endcase
    end

    assign o_last = w_last;
    assign o_done = r_done;

    // Result as it will be at the final edge
    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if (!r_is_div) begin
            o_hi = w_prod[2*WIDTH-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end else if (r_b_zero) begin
            o_hi = r_dividend;
            o_lo = '1;
        end else begin
            o_hi = r_neg_r ? (-w_rem_next) : w_rem_next;
            o_lo = r_neg_q ? (-w_quo_next) : w_quo_next;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_dividend <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (r_state == MD_IDLE) begin
                if (i_start) begin
                    r_cnt      <= '0;
                    r_is_div   <= (i_op == OP_DIV);
                    r_neg_q    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                    r_neg_r    <= i_a[WIDTH-1];
                    r_b_zero   <= (i_b == '0);
                    r_dividend <= i_a;
                    r_acc      <= '0;
                    r_mcand    <= {{WIDTH{1'b0}}, w_mag_b};
                    r_mplier   <= w_mag_a;
                    r_rem      <= '0;
                    r_quo      <= w_mag_a;
                    r_divisor  <= w_mag_b;
                end
            end else begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_rem    <= w_rem_next;
                r_quo    <= w_quo_next;
            end
        end
    end

endmodule

// File: rtl/datapath_mc.sv
// -----------------------------------------------------------------------------
// datapath_mc
// Single-bus CPU datapath: NREGS GP registers, PC, IR, MAR, MDR, HI, LO, Y and
// split Z around one shared bus, single-cycle ALU and a WIDTH-cycle signed
// MUL/DIV engine.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_rin / i_rout                 per-GP-register load enables / bus drives
//   i_pc_in .. i_lo_in             special register load enables
//   i_pc_out .. i_c_out            bus-drive selects
//   i_inc_pc                       PC += PC_STEP (PCin wins)
//   i_zin, i_operation             load Z from ALU / start MUL or DIV
//   i_read                         MDR source: 1 = i_mdatain, 0 = bus
//   i_mdatain, i_inport_data,
//   i_c_sign_ext                   external data sources
//   o_bus                          current bus value
//   o_mar_q, o_ir_q, o_mdr_q       register contents
//   o_busy, o_done                 MUL/DIV running / result-written pulse
//   o_bus_conflict                 more than one bus driver selected
// -----------------------------------------------------------------------------
module datapath_mc
    import datapath_mc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 0,
    parameter int PC_STEP = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NREGS-1:0] i_rin,
    input  logic [NREGS-1:0] i_rout,
    input  logic             i_pc_in,
    input  logic             i_ir_in,
    input  logic             i_mar_in,
    input  logic             i_mdr_in,
    input  logic             i_y_in,
    input  logic             i_hi_in,
    input  logic             i_lo_in,
    input  logic             i_pc_out,
    input  logic             i_mdr_out,
    input  logic             i_hi_out,
    input  logic             i_lo_out,
    input  logic             i_zhigh_out,
    input  logic             i_zlow_out,
    input  logic             i_inport_out,
    input  logic             i_c_out,
    input  logic             i_inc_pc,
    input  logic             i_zin,
    input  logic [OPW-1:0]   i_operation,
    input  logic             i_read,
    input  logic [WIDTH-1:0] i_mdatain,
    input  logic [WIDTH-1:0] i_inport_data,
    input  logic [WIDTH-1:0] i_c_sign_ext,
    output logic [WIDTH-1:0] o_bus,
    output logic [WIDTH-1:0] o_mar_q,
    output logic [WIDTH-1:0] o_ir_q,
    output logic [WIDTH-1:0] o_mdr_q,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_bus_conflict
);

    // Bus sources: GP registers first, then the special sources
    localparam int NSRC = NREGS + 8;

    logic [WIDTH-1:0] r_pc, r_ir, r_mar, r_mdr, r_hi, r_lo, r_y, r_zhi, r_zlo;

    logic [NSRC-1:0]             w_sel;
    logic [NSRC-1:0][WIDTH-1:0]  w_src;
    logic [NSRC-1:0][WIDTH-1:0]  w_gated;
    logic [WIDTH-1:0]            w_or;
    int                          w_nsel;
    logic                        w_conflict;

    logic             w_md_busy, w_md_last, w_md_start;
    logic [WIDTH-1:0] w_md_hi, w_md_lo;
    logic [WIDTH-1:0] w_alu_hi, w_alu_lo;
    logic [WIDTH-1:0] w_shamt;
    logic [WIDTH:0]   w_sum, w_dif;

    // ---------------- GP registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_gp
            logic [WIDTH-1:0] r_q;
            if (gi == 0 && R0_ZERO != 0) begin : g_zero
                // Hardwired zero: reads as 0, loads discarded
                assign r_q = '0;
            end else begin : g_reg
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= '0;
                    end else if (i_rin[gi]) begin
                        r_q <= o_bus;
                    end
                end
            end
            assign w_src[gi] = r_q;
        end
    endgenerate

    // ---------------- bus ----------------
    assign w_sel = {i_c_out, i_inport_out, i_zlow_out, i_zhigh_out,
                    i_lo_out, i_hi_out, i_mdr_out, i_pc_out, i_rout};

    assign w_src[NREGS]     = r_pc;
    assign w_src[NREGS + 1] = r_mdr;
    assign w_src[NREGS + 2] = r_hi;
    assign w_src[NREGS + 3] = r_lo;
    assign w_src[NREGS + 4] = r_zhi;
    assign w_src[NREGS + 5] = r_zlo;
    assign w_src[NREGS + 6] = i_inport_data;
    assign w_src[NREGS + 7] = i_c_sign_ext;

    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_gate
            assign w_gated[gi] = w_sel[gi] ? w_src[gi] : '0;
        end
    endgenerate

    always_comb begin
        w_or   = '0;
        w_nsel = 0;
        for (int k = 0; k < NSRC; k++) begin
            w_or   = w_or | w_gated[k];
            w_nsel = w_nsel + int'(w_sel[k]);
        end
    end

    // A conflicting OR of several drivers is suppressed rather than passed on
    assign w_conflict     = (w_nsel > 1);
    assign o_bus          = w_conflict ? '0 : w_or;
    assign o_bus_conflict = w_conflict;

    // ---------------- single-cycle ALU (A = Y, B = bus) ----------------
    assign w_shamt = WIDTH'(o_bus % WIDTH);
    assign w_sum   = {1'b0, r_y} + {1'b0, o_bus};
    assign w_dif   = {1'b0, r_y} - {1'b0, o_bus};

    always_comb begin
        w_alu_hi = '0;
        w_alu_lo = '0;
        case (i_operation)
            OP_ADD: begin
                w_alu_lo = w_sum[WIDTH-1:0];
                w_alu_hi = {WIDTH{w_sum[WIDTH]}};
            end
            OP_SUB: begin
                w_alu_lo = w_dif[WIDTH-1:0];
                w_alu_hi = {WIDTH{w_dif[WIDTH]}};
            end
            OP_AND:  w_alu_lo = r_y & o_bus;
            OP_OR:   w_alu_lo = r_y | o_bus;
            OP_SHR:  w_alu_lo = r_y >> w_shamt;
            OP_SHRA: w_alu_lo = $unsigned($signed(r_y) >>> w_shamt);
            OP_SHL:  w_alu_lo = r_y << w_shamt;
            // A shift by WIDTH yields 0, so amount 0 rotates correctly too
            OP_ROR:  w_alu_lo = (r_y >> w_shamt) | (r_y << (WIDTH'(WIDTH) - w_shamt));
            OP_ROL:  w_alu_lo = (r_y << w_shamt) | (r_y >> (WIDTH'(WIDTH) - w_shamt));
            OP_NEG:  w_alu_lo = -o_bus;
            OP_NOT:  w_alu_lo = ~o_bus;
            default: begin
                w_alu_hi = '0;
                w_alu_lo = '0;
            end
        endcase
    end

    // ---------------- MUL/DIV engine ----------------
    assign w_md_start = i_zin && !w_md_busy && is_multicycle(i_operation);

    muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_md_start),
        .i_a     (r_y),
        .i_b     (o_bus),
        .i_op    (i_operation),
        .o_busy  (w_md_busy),
        .o_last  (w_md_last),
        .o_done  (o_done),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo)
    );

    assign o_busy = w_md_busy;

    // ---------------- special registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
        end else begin
            if (i_pc_in) begin
                r_pc <= o_bus;
            end else if (i_inc_pc) begin
                r_pc <= r_pc + WIDTH'(PC_STEP);
            end
            if (i_ir_in)  r_ir  <= o_bus;
            if (i_mar_in) r_mar <= o_bus;
            if (i_mdr_in) r_mdr <= i_read ? i_mdatain : o_bus;
            if (i_hi_in)  r_hi  <= o_bus;
            if (i_lo_in)  r_lo  <= o_bus;
            if (i_y_in)   r_y   <= o_bus;

            // Z belongs to the engine while it runs; any Zin then is dropped
            if (w_md_last) begin
                r_zhi <= w_md_hi;
                r_zlo <= w_md_lo;
            end else if (i_zin && !w_md_busy && !is_multicycle(i_operation)) begin
                r_zhi <= w_alu_hi;
                r_zlo <= w_alu_lo;
            end
        end
    end

    assign o_mar_q = r_mar;
    assign o_ir_q  = r_ir;
    assign o_mdr_q = r_mdr;

endmodule

// File: tb/tb_datapath_mc.sv
module tb_datapath_mc;
    import datapath_mc_pkg::*;

    localparam int W = 32;
    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic [N-1:0]   rin, rout;
    logic           pc_in, ir_in, mar_in, mdr_in, y_in, hi_in, lo_in;
    logic           pc_out, mdr_out, hi_out, lo_out, zhigh_out, zlow_out, inport_out, c_out;
    logic           inc_pc, zin, rd;
    logic [OPW-1:0] op;
    logic [W-1:0]   mdatain, inport, cext;

    logic [W-1:0] bus, mar_q, ir_q, mdr_q;
    logic         busy, done, conflict;
    logic [W-1:0] bus2, mar_q2, ir_q2, mdr_q2;
    logic         busy2, done2, conflict2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_zlo = '0;
    logic [W-1:0] exp_zhi = '0;

    datapath_mc #(.WIDTH(W), .NREGS(N), .R0_ZERO(0), .PC_STEP(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rin(rin), .i_rout(rout),
        .i_pc_in(pc_in), .i_ir_in(ir_in), .i_mar_in(mar_in), .i_mdr_in(mdr_in),
        .i_y_in(y_in), .i_hi_in(hi_in), .i_lo_in(lo_in),
        .i_pc_out(pc_out), .i_mdr_out(mdr_out), .i_hi_out(hi_out), .i_lo_out(lo_out),
        .i_zhigh_out(zhigh_out), .i_zlow_out(zlow_out), .i_inport_out(inport_out), .i_c_out(c_out),
        .i_inc_pc(inc_pc), .i_zin(zin), .i_operation(op), .i_read(rd),
        .i_mdatain(mdatain), .i_inport_data(inport), .i_c_sign_ext(cext),
        .o_bus(bus), .o_mar_q(mar_q), .o_ir_q(ir_q), .o_mdr_q(mdr_q),
        .o_busy(busy), .o_done(done), .o_bus_conflict(conflict));

    datapath_mc #(.WIDTH(W), .NREGS(N), .R0_ZERO(1), .PC_STEP(1)) dut_r0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rin(rin), .i_rout(rout),
        .i_pc_in(pc_in), .i_ir_in(ir_in), .i_mar_in(mar_in), .i_mdr_in(mdr_in),
        .i_y_in(y_in), .i_hi_in(hi_in), .i_lo_in(lo_in),
        .i_pc_out(pc_out), .i_mdr_out(mdr_out), .i_hi_out(hi_out), .i_lo_out(lo_out),
        .i_zhigh_out(zhigh_out), .i_zlow_out(zlow_out), .i_inport_out(inport_out), .i_c_out(c_out),
        .i_inc_pc(inc_pc), .i_zin(zin), .i_operation(op), .i_read(rd),
        .i_mdatain(mdatain), .i_inport_data(inport), .i_c_sign_ext(cext),
        .o_bus(bus2), .o_mar_q(mar_q2), .o_ir_q(ir_q2), .o_mdr_q(mdr_q2),
        .o_busy(busy2), .o_done(done2), .o_bus_conflict(conflict2));

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rin = '0; rout = '0;
        pc_in = 0; ir_in = 0; mar_in = 0; mdr_in = 0; y_in = 0; hi_in = 0; lo_in = 0;
        pc_out = 0; mdr_out = 0; hi_out = 0; lo_out = 0; zhigh_out = 0; zlow_out = 0;
        inport_out = 0; c_out = 0; inc_pc = 0; zin = 0; rd = 0; op = OP_ADD;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_y(input logic [W-1:0] v);
        inport = v; inport_out = 1; y_in = 1;
        step(); idle();
    endtask

    task automatic load_r(input int idx, input logic [W-1:0] v);
        inport = v; inport_out = 1; rin[idx] = 1'b1;
        step(); idle();
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_alu(input logic [OPW-1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] lo, output logic [W-1:0] hi);
        int unsigned s;
        logic [2*W-1:0] aa;
        logic [2*W-1:0] rot;
        longint unsigned ua, ub;
        s  = b % 32;
        aa = {a, a};
        ua = a;
        ub = b;
        hi = '0;
        lo = '0;
        case (o)
            OP_ADD: begin lo = a + b; hi = (ua + ub > 64'hFFFF_FFFF) ? '1 : '0; end
            OP_SUB: begin lo = a - b; hi = (a < b) ? '1 : '0; end
            OP_AND: lo = a & b;
            OP_OR:  lo = a | b;
            OP_SHR: lo = a >> s;
            OP_SHRA: lo = $unsigned($signed(a) >>> s);
            OP_SHL: lo = a << s;
            OP_ROR: begin rot = aa >> s; lo = rot[W-1:0]; end
            OP_ROL: begin rot = aa << s; lo = rot[2*W-1:W]; end
            OP_NEG: lo = 32'd0 - b;
            OP_NOT: lo = ~b;
            default: lo = '0;
        endcase
    endfunction

    function automatic void ref_md(input logic [OPW-1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] lo, output logic [W-1:0] hi);
        longint sa, sb, p;
        int ia, ib, q, r;
        if (o == OP_MUL) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
            lo = p[31:0];
            hi = p[63:32];
        end else if (b == 0) begin
            lo = '1;
            hi = a;
        end else begin
            ia = $signed(a);
            ib = $signed(b);
            q  = ia / ib;
            r  = ia % ib;
            lo = q;
            hi = r;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int done_seen;
        logic [W-1:0] v;
        idle(); inport = '0; mdatain = '0; cext = '0;
        rst_n = 0;
        repeat (3) step();
        for (int k = 0; k < 6; k++) begin
            idle();
            case (k)
                0: pc_out = 1;
                1: zlow_out = 1;
                2: zhigh_out = 1;
                3: hi_out = 1;
                4: lo_out = 1;
                default: rout[5] = 1'b1;
            endcase
            #1;
            n_checks++;
            if (bus !== '0) begin
                n_fail++; $display("FAIL reset_bus_src%0d: got %h want 0", k, bus);
            end
        end
        idle();
        n_checks++;
        if ({mar_q, ir_q, mdr_q, busy, done, conflict} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: mar=%h ir=%h mdr=%h busy=%b done=%b want all 0",
                               mar_q, ir_q, mdr_q, busy, done);
        end
        n_checks++;
        if ({mar_q2, ir_q2, mdr_q2, busy2, done2, conflict2} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_r0: mar=%h ir=%h mdr=%h busy=%b want all 0",
                               mar_q2, ir_q2, mdr_q2, busy2);
        end
        rst_n = 1;
        step();

        // Abort a MUL part way through
        inport = 32'h0000_00AB; inport_out = 1; mar_in = 1; step(); idle();
        load_y(32'hFFFF_FFFD);
        inport = 32'h4000_0000; inport_out = 1; zin = 1; op = OP_MUL; step(); idle();
        repeat (10) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy_before_abort: got %b want 1", busy);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || mar_q !== '0) begin
            n_fail++; $display("FAIL reset_async_abort: busy=%b mar=%h want 0/0", busy, mar_q);
        end
        step();
        rst_n = 1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            step();
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL reset_no_done_after_abort: saw %0d busy/done cycles want 0", done_seen);
        end
        zlow_out = 1; #1; v = bus; zlow_out = 0;
        n_checks++;
        if (v !== '0) begin
            n_fail++; $display("FAIL reset_z_untouched: zlow=%h want 0", v);
        end
        exp_zlo = '0; exp_zhi = '0;
        $display("test_reset done");
    endtask

    task automatic test_add_example();
        load_r(1, 32'd5);
        load_r(2, 32'd7);
        rout[1] = 1'b1; y_in = 1; step(); idle();
        rout[2] = 1'b1; zin = 1; op = OP_ADD; step(); idle();
        zlow_out = 1; #1;
        n_checks++;
        if (bus !== 32'd12) begin n_fail++; $display("FAIL add_zlow: got %0d want 12", bus); end
        zlow_out = 0; zhigh_out = 1; #1;
        n_checks++;
        if (bus !== 32'd0) begin n_fail++; $display("FAIL add_zhigh: got %h want 0", bus); end
        idle();
        zlow_out = 1; rin[3] = 1'b1; step(); idle();
        rout[3] = 1'b1; #1;
        n_checks++;
        if (bus !== 32'd12) begin n_fail++; $display("FAIL add_r3: got %0d want 12", bus); end
        idle();
        exp_zlo = 32'd12; exp_zhi = '0;
        $display("add example: R3 = %0d", 32'd12);
    endtask

    task automatic test_alu_random();
        logic [W-1:0] a, b, elo, ehi, glo, ghi;
        logic [OPW-1:0] o;
        for (int it = 0; it < 44; it++) begin
            o = OPW'(it % 11);
            a = $urandom;
            b = (it % 3 == 0) ? W'($urandom_range(0, 70)) : W'($urandom);
            if (it % 7 == 0) b = a;
            load_y(a);
            inport = b; inport_out = 1; zin = 1; op = o; step(); idle();
            ref_alu(o, a, b, elo, ehi);
            zlow_out = 1; #1; glo = bus; zlow_out = 0;
            zhigh_out = 1; #1; ghi = bus; zhigh_out = 0;
            n_checks++;
            if (glo !== elo || ghi !== ehi) begin
                n_fail++;
                $display("FAIL alu_op%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         o, a, b, ghi, glo, ehi, elo);
            end else begin
                $display("alu op%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, ghi, glo);
            end
            exp_zlo = elo; exp_zhi = ehi;
        end
    endtask

    task automatic test_muldiv();
        logic [OPW-1:0] ops [12];
        logic [W-1:0] as [12];
        logic [W-1:0] bs [12];
        logic [W-1:0] elo, ehi, glo, ghi, gmid;
        int cnt, early;
        ops[0] = OP_MUL; as[0] = 32'hFFFF_FFFD; bs[0] = 32'h4000_0000;
        ops[1] = OP_DIV; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;
        ops[2] = OP_DIV; as[2] = 32'hFFFF_FFF9; bs[2] = 32'd0;
        ops[3] = OP_MUL; as[3] = 32'h8000_0000; bs[3] = 32'h8000_0000;
        for (int i = 4; i < 12; i++) begin
            ops[i] = (i % 2 == 0) ? OP_MUL : OP_DIV;
            as[i]  = $urandom;
            bs[i]  = (i % 4 == 1) ? W'($signed(12'($urandom))) : W'($urandom);
            if (bs[i] == 32'hFFFF_FFFF) bs[i] = 32'd3;
        end
        for (int i = 0; i < 12; i++) begin
            load_y(as[i]);
            inport = bs[i]; inport_out = 1; zin = 1; op = ops[i]; step(); idle();
            cnt = 0; early = 0; gmid = '0;
            while (busy === 1'b1 && cnt < 100) begin
                if (done === 1'b1) early++;
                cnt++;
                if (cnt == 5) begin
                    // Y scribble and a blocked Zin while busy
                    inport = $urandom; inport_out = 1; y_in = 1; zin = 1; op = OP_ADD;
                end
                step(); idle();
                if (cnt == 5) begin
                    zlow_out = 1; #1; gmid = bus; zlow_out = 0;
                    n_checks++;
                    if (gmid !== exp_zlo) begin
                        n_fail++; $display("FAIL md%0d_z_held_while_busy: got %h want %h", i, gmid, exp_zlo);
                    end
                end
            end
            n_checks++;
            if (cnt != 32 || early != 0) begin
                n_fail++; $display("FAIL md%0d_latency: busy %0d cycles (early done %0d) want 32", i, cnt, early);
            end
            n_checks++;
            if (done !== 1'b1) begin n_fail++; $display("FAIL md%0d_done_pulse: got %b want 1", i, done); end
            ref_md(ops[i], as[i], bs[i], elo, ehi);
            zlow_out = 1; #1; glo = bus; zlow_out = 0;
            zhigh_out = 1; #1; ghi = bus; zhigh_out = 0;
            n_checks++;
            if (glo !== elo || ghi !== ehi) begin
                n_fail++;
                $display("FAIL md%0d_result op%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         i, ops[i], as[i], bs[i], ghi, glo, ehi, elo);
            end else begin
                $display("muldiv op%0d a=%h b=%h -> hi=%h lo=%h", ops[i], as[i], bs[i], ghi, glo);
            end
            step();
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL md%0d_done_width: got %b want 0", i, done); end
            exp_zlo = elo; exp_zhi = ehi;
        end
    endtask

    task automatic test_bus();
        logic [W-1:0] a, b, m;
        a = $urandom | 32'h1; b = $urandom | 32'h100;
        load_r(1, a);
        load_r(2, b);
        rout[1] = 1'b1; rout[2] = 1'b1; #1;
        n_checks++;
        if (bus !== '0 || conflict !== 1'b1) begin
            n_fail++; $display("FAIL bus_conflict_r1r2: bus=%h conflict=%b want 0/1", bus, conflict);
        end
        rout[2] = 1'b0; #1;
        n_checks++;
        if (bus !== a || conflict !== 1'b0) begin
            n_fail++; $display("FAIL bus_single_r1: bus=%h conflict=%b want %h/0", bus, conflict, a);
        end
        idle(); cext = $urandom; pc_out = 1; c_out = 1; #1;
        n_checks++;
        if (bus !== '0 || conflict !== 1'b1) begin
            n_fail++; $display("FAIL bus_conflict_pc_c: bus=%h conflict=%b want 0/1", bus, conflict);
        end
        idle(); #1;
        n_checks++;
        if (bus !== '0 || conflict !== 1'b0) begin
            n_fail++; $display("FAIL bus_none: bus=%h conflict=%b want 0/0", bus, conflict);
        end
        load_r(0, 32'd9);
        rout[0] = 1'b1; #1;
        n_checks++;
        if (bus !== 32'd9 || bus2 !== 32'd0) begin
            n_fail++; $display("FAIL bus_r0: plain=%h want 9, hardwired=%h want 0", bus, bus2);
        end
        idle();
        m = $urandom; mdatain = m; inport = ~m; inport_out = 1; rd = 1; mdr_in = 1; step(); idle();
        n_checks++;
        if (mdr_q !== m) begin n_fail++; $display("FAIL mdr_read: got %h want %h", mdr_q, m); end
        inport = ~m; inport_out = 1; rd = 0; mdr_in = 1; step(); idle();
        mdr_out = 1; #1;
        n_checks++;
        if (mdr_q !== ~m || bus !== ~m) begin
            n_fail++; $display("FAIL mdr_bus: mdr=%h bus=%h want %h", mdr_q, bus, ~m);
        end
        idle();
        inport = a ^ b; inport_out = 1; mar_in = 1; ir_in = 1; step(); idle();
        n_checks++;
        if (mar_q !== (a ^ b) || ir_q !== (a ^ b)) begin
            n_fail++; $display("FAIL mar_ir_load: mar=%h ir=%h want %h", mar_q, ir_q, a ^ b);
        end
        inport = b; inport_out = 1; hi_in = 1; step(); idle();
        hi_out = 1; #1;
        n_checks++;
        if (bus !== b) begin n_fail++; $display("FAIL hi_load: got %h want %h", bus, b); end
        idle();
        $display("bus tests: r1=%h r2=%h mdr=%h", a, b, ~m);
    endtask

    task automatic test_pc();
        int n;
        inport = 32'hFFFF_FFFF; inport_out = 1; pc_in = 1; step(); idle();
        inc_pc = 1; step(); idle();
        pc_out = 1; #1;
        n_checks++;
        if (bus !== '0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", bus); end
        idle();
        inport = 32'h100; inport_out = 1; pc_in = 1; inc_pc = 1; step(); idle();
        pc_out = 1; #1;
        n_checks++;
        if (bus !== 32'h100) begin n_fail++; $display("FAIL pc_load_priority: got %h want 100", bus); end
        idle();
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin inc_pc = 1; step(); idle(); end
        pc_out = 1; #1;
        n_checks++;
        if (bus !== 32'h100 + W'(n)) begin
            n_fail++; $display("FAIL pc_inc_%0d: got %h want %h", n, bus, 32'h100 + W'(n));
        end
        idle();
        $display("pc tests: %0d increments from 0x100", n);
    endtask

    initial begin
        idle();
        inport = '0; mdatain = '0; cext = '0;
        test_reset();
        test_add_example();
        test_alu_random();
        test_muldiv();
        test_bus();
        test_pc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
